// File: rtl/inst_header_issue.sv
// Instruction header issue stage: a small FIFO between fetch and control,
// with a registered issue slot that pops one header per unstalled cycle.
module inst_header_issue #(
   parameter int         DEPTH      = 2,
   parameter logic [9:0] NOP_HEADER = 10'b0000000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstWord,
   input  logic        InstValid,
   output logic        InstReady,
   input  logic        Stall,
   input  logic        Flush,
   output logic [9:0]  InstHeader,
   output logic [21:0] InstOperands,
   output logic        HeaderValid,
   output logic [15:0] IssueCount,
   output logic [3:0]  BufLevel
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [3:0]       FULL_LVL = 4'(DEPTH);

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_t;

   occ_t             occ_q, occ_d;
   logic [3:0]       level_d;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [31:0]      mem [DEPTH];
   logic             push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Ready is held low during reset, then rises as soon as reset releases.
   assign InstReady = rst & ~Flush & (occ_q != OCC_FULL);
   assign push      = InstValid & InstReady;
   // Pop decisions use the pre-edge occupancy, so a word pushed into an empty
   // buffer is never popped on the same edge.
   assign pop       = ~Stall & ~Flush & (occ_q != OCC_EMPTY);

   // NOTE: every variable of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      level_d = BufLevel;
      occ_d   = occ_q;
      if (Flush)
         level_d = '0;
      else if (push && !pop)
         level_d = BufLevel + 4'd1;
      else if (pop && !push)
         level_d = BufLevel - 4'd1;

      if (level_d == '0)
         occ_d = OCC_EMPTY;
      else if (level_d == FULL_LVL)
         occ_d = OCC_FULL;
      else
         occ_d = OCC_PARTIAL;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q    <= OCC_EMPTY;
         BufLevel <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         occ_q    <= occ_d;
         BufLevel <= level_d;
         if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         end
      end
   end

   // NOTE: the storage array is not reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= InstWord;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         InstHeader   <= NOP_HEADER;
         InstOperands <= '0;
         HeaderValid  <= 1'b0;
         IssueCount   <= '0;
      end else if (Flush) begin
         InstHeader   <= NOP_HEADER;
         InstOperands <= '0;
         HeaderValid  <= 1'b0;
      end else if (!Stall) begin
         if (pop) begin
            InstHeader   <= mem[rd_ptr][31:22];
            InstOperands <= mem[rd_ptr][21:0];
            HeaderValid  <= 1'b1;
            IssueCount   <= IssueCount + 16'd1;
         end else begin
            InstHeader   <= NOP_HEADER;
            InstOperands <= '0;
            HeaderValid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_header_issue.sv
// Self-checking bench for inst_header_issue: a queue-based reference model
// compared every falling edge, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_inst_header_issue;

   localparam int         DEPTH = 2;
   localparam logic [9:0] NOP   = 10'b0000000000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] InstWord = '0;
   logic        InstValid = 1'b0;
   logic        InstReady;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic [9:0]  InstHeader;
   logic [21:0] InstOperands;
   logic        HeaderValid;
   logic [15:0] IssueCount;
   logic [3:0]  BufLevel;

   int n_cmp  = 0;
   int n_fail = 0;

   inst_header_issue #(.DEPTH(DEPTH), .NOP_HEADER(NOP)) dut (
      .clk(clk), .rst(rst), .InstWord(InstWord), .InstValid(InstValid),
      .InstReady(InstReady), .Stall(Stall), .Flush(Flush),
      .InstHeader(InstHeader), .InstOperands(InstOperands),
      .HeaderValid(HeaderValid), .IssueCount(IssueCount), .BufLevel(BufLevel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a plain queue; one issue slot.
   logic [31:0] m_q[$];
   logic [9:0]  m_hdr;
   logic [21:0] m_ops;
   logic        m_valid;
   logic [15:0] m_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_hdr = NOP; m_ops = '0; m_valid = 1'b0; m_cnt = '0;
      end else begin
         logic accept;
         logic [31:0] w;
         accept = InstValid && !Flush && (m_q.size() < DEPTH);
         if (Flush) begin
            m_q.delete();
            m_hdr = NOP; m_ops = '0; m_valid = 1'b0;
         end else begin
            if (!Stall) begin
               if (m_q.size() > 0) begin
                  w = m_q.pop_front();
                  m_hdr = w[31:22]; m_ops = w[21:0]; m_valid = 1'b1;
                  m_cnt = m_cnt + 16'd1;
               end else begin
                  m_hdr = NOP; m_ops = '0; m_valid = 1'b0;
               end
            end
            if (accept) m_q.push_back(InstWord);
         end
      end
   end

   always @(negedge clk) begin
      check("m_header",   32'(InstHeader),   32'(m_hdr));
      check("m_operands", 32'(InstOperands), 32'(m_ops));
      check("m_valid",    32'(HeaderValid),  32'(m_valid));
      check("m_count",    32'(IssueCount),   32'(m_cnt));
      check("m_level",    32'(BufLevel),     32'(m_q.size()));
      check("m_ready",    32'(InstReady),
            32'(rst && !Flush && (m_q.size() < DEPTH)));
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a word and hold it until a handshake edge; leaves InstValid high.
   task automatic push(input logic [31:0] w);
      logic acc;
      int   guard;
      InstWord  = w;
      InstValid = 1'b1;
      guard     = 0;
      acc       = 1'b0;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = InstReady;
         step();
         guard++;
      end
      if (!acc) check("push_timeout", 32'(acc), 32'd1);
   endtask

   task automatic do_reset();
      InstValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] saved_cnt;

   initial begin
      // Reset state
      #2;
      check("rst_ready_low", 32'(InstReady), 32'd0);
      check("rst_header",    32'(InstHeader), 32'(NOP));
      do_reset();
      check("post_rst_ready", 32'(InstReady), 32'd1);
      check("post_rst_level", 32'(BufLevel), 32'd0);
      check("post_rst_count", 32'(IssueCount), 32'd0);

      // Single word: two-cycle latency, then bubble
      push(32'h0080_0000);
      InstValid = 1'b0;
      check("single_lvl1",   32'(BufLevel), 32'd1);
      check("single_nv1",    32'(HeaderValid), 32'd0);
      step();
      check("single_hdr",    32'(InstHeader), 32'h002);
      check("single_valid",  32'(HeaderValid), 32'd1);
      check("single_cnt",    32'(IssueCount), 32'd1);
      step();
      check("single_bubble", 32'(HeaderValid), 32'd0);
      check("single_nop",    32'(InstHeader), 32'(NOP));

      // Back-to-back stream
      push({10'h012, 22'h00_0001});
      check("stream_lvl_a", 32'(BufLevel), 32'd1);
      push({10'h020, 22'h00_0002});
      check("stream_hdr_a", 32'(InstHeader), 32'h012);
      check("stream_lvl_b", 32'(BufLevel), 32'd1);
      push({10'h038, 22'h00_0003});
      InstValid = 1'b0;
      check("stream_hdr_b", 32'(InstHeader), 32'h020);
      check("stream_lvl_c", 32'(BufLevel), 32'd1);
      step();
      check("stream_hdr_c", 32'(InstHeader), 32'h038);
      check("stream_ops_c", 32'(InstOperands), 32'h3);
      check("stream_cnt",   32'(IssueCount), 32'd4);
      step();

      // Stall fill: third word held by the source
      Stall = 1'b1;
      push({10'h101, 22'h0A});
      push({10'h102, 22'h0B});
      check("fill_full_lvl",   32'(BufLevel), 32'd2);
      check("fill_ready_low",  32'(InstReady), 32'd0);
      InstWord = {10'h103, 22'h0C};
      step(2);
      check("fill_hold_lvl",   32'(BufLevel), 32'd2);
      check("fill_hold_valid", 32'(HeaderValid), 32'd0);
      Stall = 1'b0;
      push({10'h103, 22'h0C});
      InstValid = 1'b0;
      check("fill_hdr2", 32'(InstHeader), 32'h102);
      step();
      check("fill_hdr3", 32'(InstHeader), 32'h103);
      check("fill_cnt",  32'(IssueCount), 32'd7);
      step();

      // Flush with stall: buffer full, output valid
      push({10'h201, 22'h1});
      push({10'h202, 22'h2});
      Stall = 1'b1;
      push({10'h203, 22'h3});
      InstValid = 1'b0;
      check("flush_pre_lvl",   32'(BufLevel), 32'd2);
      check("flush_pre_valid", 32'(HeaderValid), 32'd1);
      saved_cnt = m_cnt;
      Flush = 1'b1;
      #1;
      check("flush_ready_low", 32'(InstReady), 32'd0);
      step();
      Flush = 1'b0;
      check("flush_valid", 32'(HeaderValid), 32'd0);
      check("flush_hdr",   32'(InstHeader), 32'(NOP));
      check("flush_lvl",   32'(BufLevel), 32'd0);
      check("flush_cnt",   32'(IssueCount), 32'(saved_cnt));
      check("flush_cnt_lit", 32'(IssueCount), 32'd8);
      Stall = 1'b0;
      step(2);
      check("flush_no_stale", 32'(HeaderValid), 32'd0);

      // Async reset between edges with two words buffered
      Stall = 1'b1;
      push({10'h301, 22'h5});
      push({10'h302, 22'h6});
      InstValid = 1'b0;
      check("areset_pre_lvl", 32'(BufLevel), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      check("areset_lvl",   32'(BufLevel), 32'd0);
      check("areset_cnt",   32'(IssueCount), 32'd0);
      check("areset_ready", 32'(InstReady), 32'd0);
      check("areset_valid", 32'(HeaderValid), 32'd0);
      step();
      rst = 1'b1;
      #1;
      check("areset_ready_up", 32'(InstReady), 32'd1);
      Stall = 1'b0;
      step(3);
      check("areset_no_issue", 32'(IssueCount), 32'd0);
      check("areset_no_valid", 32'(HeaderValid), 32'd0);

      // Counter wrap: 65537 issues from reset
      do_reset();
      for (int i = 0; i < 65537; i++) push($urandom);
      InstValid = 1'b0;
      step(3);
      check("wrap_cnt", 32'(IssueCount), 32'd1);
      check("wrap_lvl", 32'(BufLevel), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_header_issue.md
INST_HEADER_ISSUE -- requirements
Module: inst_header_issue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, giving the number of instruction-buffer entries (legal values 2..8).
REQ-002 The module SHALL have parameter NOP_HEADER, default 10'b0000000000, giving the bubble header driven when no valid instruction is issued.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port InstWord, input, 32 bits: fetched instruction; bits [31:22] are the header, bits [21:0] are the operand field.
REQ-006 The module SHALL have port InstValid, input, 1 bit: InstWord is valid this cycle.
REQ-007 The module SHALL have port InstReady, output, 1 bit: the module accepts InstWord this cycle.
REQ-008 The module SHALL have port Stall, input, 1 bit: hold the issued header.
REQ-009 The module SHALL have port Flush, input, 1 bit: discard all buffered and issued instructions.
REQ-010 The module SHALL have port InstHeader, output, 10 bits: header presented to the control unit.
REQ-011 The module SHALL have port InstOperands, output, 22 bits: operand field paired with InstHeader.
REQ-012 The module SHALL have port HeaderValid, output, 1 bit: InstHeader/InstOperands carry a real instruction.
REQ-013 The module SHALL have port IssueCount, output, 16 bits: number of valid headers issued since reset.
REQ-014 The module SHALL have port BufLevel, output, 4 bits: current number of occupied buffer entries.

Function
REQ-015 The module SHALL complete a handshake (push) on a rising edge where InstValid=1, InstReady=1 and Flush=0.
REQ-016 InstReady SHALL be 1 exactly when BufLevel < DEPTH and Flush=0 (combinational; no same-cycle bypass when full).
REQ-017 The buffer SHALL be FIFO-ordered, with circular read/write pointers that wrap from DEPTH-1 to 0.
REQ-018 The occupancy state SHALL be EMPTY (level 0), PARTIAL (1..DEPTH-1) or FULL (DEPTH).
REQ-019 Occupancy SHALL update as follows: push only -> +1; pop only -> -1; simultaneous push and pop -> unchanged.
REQ-020 The output register SHALL update on each edge with Stall=0 and Flush=0: if the buffer is non-empty, it pops the head into InstHeader/InstOperands with HeaderValid=1; otherwise InstHeader=NOP_HEADER, InstOperands=0, HeaderValid=0.
REQ-021 With Stall=1 and Flush=0, the output register SHALL hold, no pop SHALL occur, and pushes SHALL continue until FULL.
REQ-022 Latency SHALL be 2 cycles: a word pushed at edge N appears on InstHeader after edge N+1, provided the buffer was empty and Stall=0.
REQ-023 Sustained throughput with Stall=0 and InstValid=1 SHALL be one instruction per cycle.
REQ-024 A push into an empty buffer SHALL NOT be popped on the same edge.
REQ-025 Flush SHALL be synchronous and take priority over Stall, push and pop: on that edge, pointers and level clear and the output becomes a bubble (NOP_HEADER, operands 0, HeaderValid=0).
REQ-026 IssueCount SHALL increment by 1 on every edge that loads HeaderValid=1, wrapping from 16'hFFFF to 0.
REQ-027 IssueCount SHALL NOT be changed by Flush.
REQ-028 All outputs SHALL be registered except InstReady.

Reset
REQ-029 While rst=0, the module SHALL immediately force: InstHeader=NOP_HEADER, InstOperands=0, HeaderValid=0, IssueCount=0, BufLevel=0, pointers=0, InstReady=0.
REQ-030 After rst deasserts, InstReady SHALL rise to 1 without waiting for a clock edge (level 0).
REQ-031 Reset asserted mid-operation SHALL discard buffered words; no partial issue SHALL occur after release.

Verification
REQ-032 Single word: reset, push 32'h00800000 (header 10'b0000000010) with Stall=0 -> two edges later InstHeader=10'b0000000010, HeaderValid=1, IssueCount=1; next edge bubble.
REQ-033 Stream: push headers 0x012, 0x020, 0x038 back-to-back -> they issue in order on consecutive cycles, and BufLevel never exceeds 1.
REQ-034 Stall fill: Stall=1 while pushing 3 words with DEPTH=2 -> InstReady drops after 2 pushes, the third word is held by the source, and the output is unchanged; release Stall -> all 3 issue in order.
REQ-035 Flush: buffer FULL, output valid, Flush=1 with Stall=1 -> next cycle HeaderValid=0, InstHeader=NOP_HEADER, BufLevel=0, and IssueCount is unchanged.
REQ-036 Wrap: issue 65537 valid headers -> IssueCount=1; FIFO pointers wrap repeatedly with no ordering error.
REQ-037 Async reset: assert rst=0 between edges with BufLevel=2 -> outputs reach reset values before the next edge; after release, no stale header is issued.
